selftest_seq: RTL and testbench
===============================

// Module: selftest_seq
// PURPOSE
//  Parametrised on-chip self-test sequencer for the modular-arithmetic cores (multmod, divmod, point_add, scalarmult*).
//  Walks NVEC test vectors and drives the core's req/res four-phase handshake for each one.
//  Compares NRES result words against expected values and keeps pass/fail counters for the LEDs/test points.
//  Sits between the PLL-clocked top and one DUT; the vector/expected ROM stays outside and is addressed by vec_idx.
// PARAMETERS
//  W       448  width of one result word (bits)
//  NRES    2    result words compared per vector (1 = scalar result, 2 = x,y point)
//  NVEC    4    number of vectors per pass, >=1
//  CW      8    pass/fail counter width
//  LOOP    0    1 = restart at vector 0 after the last vector; 0 = stop and assert done
//  TMO     24   watchdog width; timeout after 2**TMO-1 cycles (used only with SELFTEST_WATCHDOG_EN)
// PORTS
//  clk            in   1        system clock (refclk domain)
//  rst            in   1        synchronous reset, active-high
//  start          in   1        1-cycle pulse; begins a pass from IDLE, ignored otherwise
//  vec_idx        out  clog2(NVEC)  current vector index -> external ROM
//  exp_in         in   NRES*W   expected result words for vec_idx, word 0 in LSBs
//  res_in         in   NRES*W   DUT result words, word 0 = x3/Z
//  req_valid      out  1        request to DUT
//  req_ready      in   1        DUT accepted request
//  req_busy       in   1        DUT computing (status only)
//  res_valid      in   1        DUT result valid
//  res_ready      out  1        result consumed
//  pass_count     out  CW       vectors matched (saturates at all-ones)
//  fail_count     out  CW       vectors mismatched or timed out (saturates)
//  busy           out  1        pass in progress
//  done           out  1        pass complete (LOOP=0), held until start or rst
//  timeout        out  1        sticky watchdog flag (0 if macro absent)
// BEHAVIOUR
//  Reset: state IDLE; vec_idx=0, req_valid=0, res_ready=0, counters=0, busy=0, done=0, timeout=0.
//  States: IDLE -> ISSUE -> WAIT -> CHECK -> RELEASE -> (ISSUE for the next vector | IDLE).
//  IDLE: on start, clear counters, clear done and timeout, set vec_idx=0, go to ISSUE next cycle.
//  ISSUE: req_valid=1 until the cycle req_ready=1 is sampled; req_valid=0 from the next cycle; go to WAIT.
//  WAIT: on res_valid=1 go to CHECK. res_valid that is already high on entry is accepted.
//  CHECK (exactly 1 cycle): compare all NRES words of res_in and exp_in (full W-bit equality).
//    Match: pass_count+1. Else: fail_count+1. Then set res_ready=1 and go to RELEASE.
//  RELEASE: hold res_ready=1 until res_valid=0 is sampled, then drop res_ready in the same cycle.
//    Then: if vec_idx==NVEC-1, wrap to 0; with LOOP=0 -> IDLE, done=1. Otherwise vec_idx+1 -> ISSUE.
//  Minimum per-vector overhead: 4 cycles plus DUT latency.
//  Counters saturate and never wrap. If pass and fail are both possible in a cycle, only one increments per vector.
//  start while busy: ignored. rst at any point: return to reset values within 1 cycle.
//    req_valid/res_ready drop at once; the DUT must be reset by the same rst.
//  vec_idx changes only in RELEASE->ISSUE and IDLE->ISSUE, so exp_in is stable for >=2 cycles before CHECK.
// CONFIGURATION
//  SELFTEST_WATCHDOG_EN defined: a TMO-bit counter clears on entering ISSUE and counts in ISSUE/WAIT.
//    At all-ones: timeout=1 (sticky), fail_count+1, skip to the NEXT-vector decision.
//    Skipping does not go through RELEASE; req_valid and res_ready are forced to 0.
//  SELFTEST_WATCHDOG_EN not defined: no counter; timeout tied to 0; a hung DUT leaves the block in ISSUE/WAIT.
// STRUCTURE
//  selftest_pkg: state localparams (ST_IDLE..ST_RELEASE, 3-bit) and the saturating-increment function.
//  One sub-module, selftest_cmp: NRES*W equality reducer, combinational, registered output optional for timing.
//  FSM, counters and watchdog stay in selftest_seq.
// TESTING (mock DUT with programmable latency and results; W=448, NRES=2, NVEC=4, CW=8)
//  1. rst, start; mock returns exp for all 4 vectors after 10 cycles -> pass=4, fail=0, done=1, vec_idx=0.
//  2. Vector 2 result x off by 1 (P448-1 vs P448-2) -> pass=3, fail=1.
//  3. req_ready delayed 5 cycles; res_valid held 3 cycles after res_ready -> req_valid high exactly 6 cycles, res_ready falls the cycle res_valid=0.
//  4. CW=2, LOOP=1, 10 matching vectors -> pass_count stays 3, no wrap.
//  5. rst asserted in WAIT -> next cycle req_valid=0, res_ready=0, busy=0; a new start runs cleanly.
//  6. SELFTEST_WATCHDOG_EN, TMO=4; mock never answers vector 1 -> timeout=1 after 15 cycles, fail=1, pass=3.

Source files
------------

// File: rtl/selftest_pkg.sv
// Shared state encoding and counter helper for the self-test sequencer.
// Used by selftest_seq and selftest_cmp.
package selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Saturating +1 for a counter of width cw (cw <= 64).
  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input int unsigned cw
  );
    logic [63:0] top;
    top = (cw >= 64) ? '1 : ((64'd1 << cw) - 64'd1);
    return (v >= top) ? top : v + 64'd1;
  endfunction

endpackage

// File: rtl/selftest_seq_if.sv
// Request/result four-phase handshake between the sequencer and one core.
// master = sequencer side, slave = arithmetic core side.
interface selftest_seq_if #(
  parameter int DW = 896
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_busy;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_in;

  modport master (
    output req_valid, res_ready,
    input  req_ready, req_busy, res_valid, res_in
  );

  modport slave (
    input  req_valid, res_ready,
    output req_ready, req_busy, res_valid, res_in
  );
endinterface

// File: rtl/selftest_cmp.sv
// NRES x W-bit equality reducer; REG=1 adds one output register for timing.
// Inputs are stable across WAIT->CHECK, so the registered form stays correct.
module selftest_cmp
  import selftest_pkg::*;
#(
  parameter int W    = 448,
  parameter int NRES = 2,
  parameter bit REG  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRES*W-1:0] a,
  input  logic [NRES*W-1:0] b,
  output logic              eq
);

  logic [NRES-1:0] word_eq;

  always_comb begin
    word_eq = '0;
    for (int i = 0; i < NRES; i++)
      word_eq[i] = (a[i*W +: W] == b[i*W +: W]);
  end

  if (REG) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) eq <= 1'b0;
      else     eq <= &word_eq;
    end
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk ^ rst;
    assign eq = &word_eq;
  end

endmodule

// File: rtl/selftest_seq.sv
// Self-test sequencer: walks NVEC vectors through one core, counts pass/fail.
// Optional watchdog: define SELFTEST_WATCHDOG_EN.
module selftest_seq
  import selftest_pkg::*;
#(
  parameter int W       = 448,
  parameter int NRES    = 2,
  parameter int NVEC    = 4,
  parameter int CW      = 8,
  parameter bit LOOP    = 1'b0,
  parameter int TMO     = 24,
  parameter bit CMP_REG = 1'b0,
  localparam int VW = (NVEC > 1) ? $clog2(NVEC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [VW-1:0]     vec_idx,
  input  logic [NRES*W-1:0] exp_in,
  selftest_seq_if.master    core,
  output logic [CW-1:0]     pass_count,
  output logic [CW-1:0]     fail_count,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam logic [VW-1:0] LAST = VW'(NVEC - 1);

  state_t state;
  logic   eq;
  logic   last;
  logic   adv;
  logic   wd_hit;
  logic   unused_busy;

  assign unused_busy = core.req_busy;
  assign last = (vec_idx == LAST);

  selftest_cmp #(
    .W    (W),
    .NRES (NRES),
    .REG  (CMP_REG)
  ) u_cmp (
    .clk (clk),
    .rst (rst),
    .a   (core.res_in),
    .b   (exp_in),
    .eq  (eq)
  );

`ifdef SELFTEST_WATCHDOG_EN
  // Fires on the cycle the counter would reach all-ones.
  localparam logic [TMO-1:0] WD_LAST = {{(TMO-1){1'b1}}, 1'b0};
  logic [TMO-1:0] wd;
  assign wd_hit = (state == ST_ISSUE || state == ST_WAIT)
                  && (wd == WD_LAST);
`else
  assign wd_hit = 1'b0;
`endif

  assign adv = (state == ST_RELEASE && !core.res_valid) || wd_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      vec_idx        <= '0;
      core.req_valid <= 1'b0;
      core.res_ready <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
`ifdef SELFTEST_WATCHDOG_EN
      wd             <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            pass_count     <= '0;
            fail_count     <= '0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            vec_idx        <= '0;
            busy           <= 1'b1;
            core.req_valid <= 1'b1;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!core.req_valid) begin
            core.req_valid <= 1'b1;
          end else if (core.req_ready) begin
            core.req_valid <= 1'b0;
            state          <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (core.res_valid) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (eq)
            pass_count <= CW'(sat_inc(64'(pass_count), CW));
          else
            fail_count <= CW'(sat_inc(64'(fail_count), CW));
          core.res_ready <= 1'b1;
          state          <= ST_RELEASE;
        end
        ST_RELEASE: ;
        default: state <= ST_IDLE;
      endcase

`ifdef SELFTEST_WATCHDOG_EN
      if (state == ST_ISSUE || state == ST_WAIT) wd <= wd + 1'b1;
      if (state == ST_IDLE) wd <= '0;
      if (wd_hit) begin
        timeout        <= 1'b1;
        fail_count     <= CW'(sat_inc(64'(fail_count), CW));
        core.res_ready <= 1'b0;
      end
`endif

      // After a timeout the request line gets one low cycle before reissue.
      if (adv) begin
        core.res_ready <= 1'b0;
        if (last && !LOOP) begin
          state          <= ST_IDLE;
          busy           <= 1'b0;
          done           <= 1'b1;
          vec_idx        <= '0;
          core.req_valid <= 1'b0;
        end else begin
          state          <= ST_ISSUE;
          vec_idx        <= last ? '0 : vec_idx + VW'(1);
          core.req_valid <= !wd_hit;
`ifdef SELFTEST_WATCHDOG_EN
          wd             <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_selftest_seq.sv
// Bench for selftest_seq: mock cores with programmable latency/results,
// queue-based scoreboard checked whenever the sequencer consumes a result.
module tb_selftest_seq;
  localparam int W = 448;
  localparam int DW = 2 * W;
  localparam int M_IDLE = 0, M_LAT = 1, M_RES = 2, M_HANG = 3;

  typedef struct {
    int p;
    int f;
  } cnt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_b = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] rom [4];
  logic [1:0]    vec_a, vec_b;
  logic [DW-1:0] exp_a, exp_b;
  logic [7:0]    pass_a, fail_a;
  logic [1:0]    pass_b, fail_b;
  logic          busy_a, done_a, to_a;
  logic          busy_b, done_b, to_b;

  assign exp_a = rom[vec_a];
  assign exp_b = rom[vec_b];

  selftest_seq_if #(.DW(DW)) ifa ();
  selftest_seq_if #(.DW(DW)) ifb ();

  selftest_seq #(
    .W(W), .NRES(2), .NVEC(4), .CW(8), .LOOP(1'b0), .TMO(4)
  ) u_a (
    .clk(clk), .rst(rst), .start(start), .vec_idx(vec_a),
    .exp_in(exp_a), .core(ifa), .pass_count(pass_a),
    .fail_count(fail_a), .busy(busy_a), .done(done_a),
    .timeout(to_a)
  );

  selftest_seq #(
    .W(W), .NRES(2), .NVEC(4), .CW(2), .LOOP(1'b1), .TMO(4)
  ) u_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_idx(vec_b),
    .exp_in(exp_b), .core(ifb), .pass_count(pass_b),
    .fail_count(fail_b), .busy(busy_b), .done(done_b),
    .timeout(to_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Mock core A
  int rdly = 0, lat = 10, hold = 1;
  logic [3:0] bad = '0, hang = '0;
  int m_st, rv_cnt, lcnt, hcnt, cur;

  function automatic logic [DW-1:0] mk_res(int v);
    logic [DW-1:0] r;
    r = rom[v];
    r[W-1:0] = r[W-1:0] - W'(bad[v]);
    return r;
  endfunction

  assign ifa.req_ready = (m_st == M_IDLE) && ifa.req_valid
                         && (rv_cnt >= rdly);
  assign ifa.req_busy = (m_st == M_LAT) || (m_st == M_HANG);

  always @(posedge clk) begin
    if (rst) begin
      m_st <= M_IDLE; rv_cnt <= 0; lcnt <= 0; hcnt <= 0; cur <= 0;
      ifa.res_valid <= 1'b0; ifa.res_in <= '0;
    end else begin
      case (m_st)
        M_IDLE:
          if (ifa.req_valid) begin
            if (ifa.req_ready) begin
              rv_cnt <= 0; lcnt <= 0; cur <= int'(vec_a);
              m_st <= hang[vec_a] ? M_HANG : M_LAT;
            end else rv_cnt <= rv_cnt + 1;
          end else rv_cnt <= 0;
        M_LAT:
          if (lcnt + 1 >= lat) begin
            ifa.res_valid <= 1'b1; ifa.res_in <= mk_res(cur);
            hcnt <= 0; m_st <= M_RES;
          end else lcnt <= lcnt + 1;
        M_RES:
          if (ifa.res_ready) begin
            if (hcnt + 1 >= hold) begin
              ifa.res_valid <= 1'b0; m_st <= M_IDLE;
            end else hcnt <= hcnt + 1;
          end
        M_HANG: if (to_a) m_st <= M_IDLE;
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // Mock core B: always correct, 2-cycle latency
  int mb, lb;
  assign ifb.req_ready = ifb.req_valid && (mb == 0);
  assign ifb.req_busy = (mb == 1);

  always @(posedge clk) begin
    if (rst) begin
      mb <= 0; lb <= 0; ifb.res_valid <= 1'b0; ifb.res_in <= '0;
    end else begin
      case (mb)
        0: if (ifb.req_valid) begin mb <= 1; lb <= 0; end
        1: if (lb == 1) begin
             ifb.res_valid <= 1'b1; ifb.res_in <= rom[vec_b]; mb <= 2;
           end else lb <= lb + 1;
        default: if (ifb.res_ready) begin
             ifb.res_valid <= 1'b0; mb <= 0;
           end
      endcase
    end
  end

  // Scoreboard monitors
  cnt_t vq[$], dq[$];
  int   qb[$];
  logic rr_q = 1'b0, dn_q = 1'b0, rrb_q = 1'b0;
  int   rv_run = 0, rv_len = 0, rr_run = 0, rr_len = 0;

  always @(negedge clk) begin
    cnt_t e;
    if (ifa.res_ready && !rr_q) begin
      if (vq.size() == 0) begin
        checks++; errors++;
        $display("FAIL vec_unexpected: result consumed, none expected");
      end else begin
        e = vq.pop_front();
        chk("vec_pass", 64'(pass_a), 64'(e.p));
        chk("vec_fail", 64'(fail_a), 64'(e.f));
      end
    end
    if (done_a && !dn_q) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: done rose, none expected");
      end else begin
        e = dq.pop_front();
        chk("done_pass", 64'(pass_a), 64'(e.p));
        chk("done_fail", 64'(fail_a), 64'(e.f));
        chk("done_vec_idx", 64'(vec_a), 64'd0);
      end
    end
    if (ifb.res_ready && !rrb_q) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: result consumed, none expected");
      end else chk("b_pass_sat", 64'(pass_b), 64'(qb.pop_front()));
    end
    rr_q = ifa.res_ready; dn_q = done_a; rrb_q = ifb.res_ready;
    if (rst) begin
      rv_run = 0; rr_run = 0;
    end else begin
      if (ifa.req_valid) rv_run++;
      else if (rv_run > 0) begin rv_len = rv_run; rv_run = 0; end
      if (ifa.res_ready) rr_run++;
      else if (rr_run > 0) begin rr_len = rr_run; rr_run = 0; end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_pass();
    int p, f;
    p = 0; f = 0;
    for (int v = 0; v < 4; v++) begin
      if (hang[v]) f++;
      else begin
        if (bad[v]) f++; else p++;
        vq.push_back('{p: p, f: f});
      end
    end
    dq.push_back('{p: p, f: f});
  endtask

  task automatic run_a(bit mid_start);
    bit ok;
    push_pass();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (mid_start && i == 20) pulse_start();
      else @(negedge clk);
      if (done_a) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL pass_timeout: done=0 required 1");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] p448;
    p448 = '1;
    p448 = p448 - (448'd1 << 224);
    for (int v = 0; v < 4; v++)
      rom[v] = {p448 ^ W'(v * 1234567 + 99),
                (v == 2) ? p448 - W'(1) : p448 - W'(10 + v)};

    repeat (3) @(negedge clk);
    chk("rst_vec_idx", 64'(vec_a), 0);
    chk("rst_req_valid", 64'(ifa.req_valid), 0);
    chk("rst_res_ready", 64'(ifa.res_ready), 0);
    chk("rst_pass", 64'(pass_a), 0);
    chk("rst_fail", 64'(fail_a), 0);
    chk("rst_busy", 64'(busy_a), 0);
    chk("rst_done", 64'(done_a), 0);
    chk("rst_timeout", 64'(to_a), 0);
    rst = 1'b0;
    @(negedge clk);

    rdly = 0; lat = 10; hold = 1; bad = '0; hang = '0;
    run_a(1'b0);
    chk("t1_req_valid_len", 64'(rv_len), 1);
    chk("t1_res_ready_len", 64'(rr_len), 2);
    chk("t1_busy_after", 64'(busy_a), 0);

    bad = 4'b0100;
    run_a(1'b1);

    bad = '0; rdly = 5; lat = 3; hold = 3;
    run_a(1'b0);
    chk("t3_req_valid_len", 64'(rv_len), 6);
    chk("t3_res_ready_len", 64'(rr_len), 4);

    rdly = 0; lat = 30; hold = 1;
    pulse_start();
    for (int i = 0; i < 100 && ifa.req_valid; i++) @(negedge clk);
    chk("t5_in_wait", 64'(ifa.req_valid), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_req_valid", 64'(ifa.req_valid), 0);
    chk("t5_res_ready", 64'(ifa.res_ready), 0);
    chk("t5_busy", 64'(busy_a), 0);
    rst = 1'b0;
    lat = 10;
    run_a(1'b0);

    do_reset();
    lat = 2; hang = 4'b0010;
`ifdef SELFTEST_WATCHDOG_EN
    begin
      int c0, t1;
      bit ok;
      c0 = -1; t1 = -1; ok = 1'b0;
      push_pass();
      pulse_start();
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (vec_a == 2'd1 && ifa.req_valid && c0 < 0) c0 = i;
        if (to_a && t1 < 0) t1 = i;
        if (done_a) begin ok = 1'b1; break; end
      end
      chk("t6_done", 64'(ok), 1);
      chk("t6_tmo_cycles", 64'(t1 - c0), 15);
      chk("t6_timeout", 64'(to_a), 1);
      repeat (2) @(negedge clk);
    end
`else
    vq.push_back('{p: 1, f: 0});
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (vec_a == 2'd1 && !ifa.req_valid) break;
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    chk("t6_hung_busy", 64'(busy_a), 1);
    chk("t6_hung_timeout", 64'(to_a), 0);
    chk("t6_hung_req_valid", 64'(ifa.req_valid), 0);
    chk("t6_hung_pass", 64'(pass_a), 1);
    chk("t6_hung_fail", 64'(fail_a), 0);
`endif
    hang = '0;
    do_reset();

    for (int k = 1; k <= 10; k++) qb.push_back(k < 3 ? k : 3);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 500 && qb.size() != 0; i++) @(negedge clk);
    chk("t4_remaining", 64'(qb.size()), 0);
    chk("t4_pass", 64'(pass_b), 3);
    chk("t4_fail", 64'(fail_b), 0);
    chk("t4_busy", 64'(busy_b), 1);
    chk("t4_done", 64'(done_b), 0);
    do_reset();

    chk("vq_left", 64'(vq.size()), 0);
    chk("dq_left", 64'(dq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
